ps2_host_ctrl: RTL and testbench

- Host-side sequencer for the PS/2 port. Owns the ps2_rx receiver's hold_req/rx_en controls and the ps2_tx transmitter's start strobe.
- Forwards device-to-host bytes (scancodes) to the user side.
- Accepts host-to-device command bytes from the user side and runs the full exchange: inhibit, transmit, wait for ACK (0xFA), retry on RESEND (0xFE) or bad reply, timeout.
- Sits between ps2_rx/ps2_tx and the system bus adapter.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_ctrl_timer.sv | 28 ++
 rtl/ps2_host_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host sequencer.
package ps2_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_DONE
  } ps2_state_e;

  // Device reply bytes
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Command completion status
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RETRY   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // One received byte as seen by the sequencer
  typedef struct packed {
    logic       vld;
    logic [7:0] data;
    logic       err;
  } ps2_rcv_t;

  // Fold the receiver's qualified error flags into one
  function automatic logic rcv_has_err(input logic parity_err, input logic no_stop_err);
    return parity_err | no_stop_err;
  endfunction

endpackage

// File: rtl/ps2_ctrl_timer.sv
// Loadable down-counter with an expiry flag; shared by the inhibit and ACK-wait phases.
module ps2_ctrl_timer #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired_c
);

  logic [WIDTH-1:0] r_cnt;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-side sequencer: forwards device bytes, runs command exchanges
// (inhibit, transmit, wait for ACK, retry, timeout).
// Optional feature macro: PS2_AUTO_RESEND_EN (autonomous RESEND on an errored idle byte).
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5000,
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic       key_vld,
  output logic [7:0] key_data,
  output logic       key_err,
  output logic       hold_req,
  output logic       rx_en,
  input  logic [7:0] rcv_data,
  input  logic       rcv_vld,
  input  logic       rcv_parity_err,
  input  logic       rcv_no_stop_err,
  input  logic       rcv_idle,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done
);

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned RTY_W   = 3;

  ps2_state_e r_state, w_state_nxt;

  logic             r_hold_req, r_rx_en, r_tx_start, r_rsp_valid, r_key_vld, r_key_err;
  logic [1:0]       r_rsp_status, w_rsp_status_nxt;
  logic [7:0]       r_key_data, w_key_data_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic [RTY_W-1:0] r_retry_cnt, w_retry_nxt;
  logic             w_key_vld_nxt, w_key_err_nxt;
  logic             w_tmr_load, w_tmr_en, w_tmr_exp;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_auto_active;
  logic             w_cmd_ready_c;
  ps2_rcv_t         w_rcv;

`ifdef PS2_AUTO_RESEND_EN
  logic r_auto, w_auto_nxt;
  logic r_err_flag, w_err_flag_nxt;
  assign w_auto_active = r_auto;
`else
  assign w_auto_active = 1'b0;
`endif

  assign w_rcv = '{vld: rcv_vld, data: rcv_data, err: rcv_has_err(rcv_parity_err, rcv_no_stop_err)};

  // Commands only accepted while idle and no device frame is arriving
  assign w_cmd_ready_c = (r_state == S_IDLE) && rcv_idle && !rcv_vld;

  // Shared phase timer
  ps2_ctrl_timer #(.WIDTH(TMR_W)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_tmr_load),
    .i_load_val  (w_tmr_val),
    .i_en        (w_tmr_en),
    .o_expired_c (w_tmr_exp)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_tx_data_nxt    = r_tx_data;
    w_retry_nxt      = r_retry_cnt;
    w_key_vld_nxt    = 1'b0;
    w_key_err_nxt    = 1'b0;
    w_key_data_nxt   = r_key_data;
    w_rsp_status_nxt = r_rsp_status;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;
    w_tmr_en         = 1'b0;
`ifdef PS2_AUTO_RESEND_EN
    w_auto_nxt       = r_auto;
    w_err_flag_nxt   = r_err_flag;
`endif

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && w_cmd_ready_c) begin
          w_tx_data_nxt = cmd_data;
          w_retry_nxt   = '0;
          w_state_nxt   = S_HOLD;
          w_tmr_load    = 1'b1;
          w_tmr_val     = TMR_W'(HOLD_CYCLES - 1);
        end else if (w_rcv.vld) begin
          if (!w_rcv.err) begin
            w_key_vld_nxt  = 1'b1;
            w_key_data_nxt = w_rcv.data;
`ifdef PS2_AUTO_RESEND_EN
            w_err_flag_nxt = 1'b0;
`endif
          end else begin
`ifdef PS2_AUTO_RESEND_EN
            // First bad byte asks the device to resend; a second one is reported
            if (r_err_flag) begin
              w_key_err_nxt  = 1'b1;
              w_err_flag_nxt = 1'b0;
            end else begin
              w_err_flag_nxt = 1'b1;
              w_auto_nxt     = 1'b1;
              w_tx_data_nxt  = PS2_RESEND;
              w_state_nxt    = S_HOLD;
              w_tmr_load     = 1'b1;
              w_tmr_val      = TMR_W'(HOLD_CYCLES - 1);
            end
`else
            w_key_err_nxt = 1'b1;
`endif
          end
        end
      end

      S_HOLD: begin
        w_tmr_en = 1'b1;
        if (w_tmr_exp) w_state_nxt = S_SEND;
      end

      S_SEND: begin
        w_state_nxt = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (tx_done) begin
          if (w_auto_active) begin
            w_state_nxt = S_IDLE;
`ifdef PS2_AUTO_RESEND_EN
            w_auto_nxt  = 1'b0;
`endif
          end else begin
            w_state_nxt = S_WAIT_ACK;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(ACK_TIMEOUT - 1);
          end
        end
      end

      S_WAIT_ACK: begin
        w_tmr_en = 1'b1;
        if (w_rcv.vld) begin
          if (!w_rcv.err && (w_rcv.data == PS2_ACK)) begin
            w_state_nxt      = S_DONE;
            w_rsp_status_nxt = ST_OK;
          end else if (w_rcv.err || (w_rcv.data == PS2_RESEND)) begin
            if (r_retry_cnt < RTY_W'(MAX_RETRY)) begin
              w_retry_nxt = r_retry_cnt + RTY_W'(1);
              w_state_nxt = S_HOLD;
              w_tmr_load  = 1'b1;
              w_tmr_val   = TMR_W'(HOLD_CYCLES - 1);
            end else begin
              w_state_nxt      = S_DONE;
              w_rsp_status_nxt = ST_RETRY;
            end
          end
        end else if (w_tmr_exp) begin
          w_state_nxt      = S_DONE;
          w_rsp_status_nxt = ST_TIMEOUT;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_req   <= 1'b0;
      r_rx_en      <= 1'b1;
      r_tx_start   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
      r_key_vld    <= 1'b0;
      r_key_err    <= 1'b0;
      r_key_data   <= 8'h00;
      r_tx_data    <= 8'h00;
      r_retry_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_req   <= (w_state_nxt == S_HOLD);
      r_rx_en      <= !((w_state_nxt == S_HOLD) || (w_state_nxt == S_SEND) ||
                        (w_state_nxt == S_WAIT_TX));
      r_tx_start   <= (w_state_nxt == S_SEND);
      r_rsp_valid  <= (w_state_nxt == S_DONE);
      r_rsp_status <= w_rsp_status_nxt;
      r_key_vld    <= w_key_vld_nxt;
      r_key_err    <= w_key_err_nxt;
      r_key_data   <= w_key_data_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_retry_cnt  <= w_retry_nxt;
    end
  end

`ifdef PS2_AUTO_RESEND_EN
  // Auto-resend bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_auto     <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_auto     <= w_auto_nxt;
      r_err_flag <= w_err_flag_nxt;
    end
  end
`endif

  assign cmd_ready  = w_cmd_ready_c;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign key_vld    = r_key_vld;
  assign key_data   = r_key_data;
  assign key_err    = r_key_err;
  assign hold_req   = r_hold_req;
  assign rx_en      = r_rx_en;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Scoreboard bench for ps2_host_ctrl: stimulus pushes expected events, a monitor pops them.
module tb_ps2_host_ctrl;

  localparam int unsigned HOLD = 10;
  localparam int unsigned TMO  = 50;
  localparam int unsigned MAXR = 3;

  typedef enum int {EV_KEY, EV_KERR, EV_TXS, EV_RSP} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic       key_vld, key_err;
  logic [7:0] key_data;
  logic       hold_req, rx_en;
  logic [7:0] rcv_data;
  logic       rcv_vld, rcv_parity_err, rcv_no_stop_err, rcv_idle;
  logic       tx_start, tx_done;
  logic [7:0] tx_data;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  ps2_host_ctrl #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .rsp_valid       (rsp_valid),
    .rsp_status      (rsp_status),
    .key_vld         (key_vld),
    .key_data        (key_data),
    .key_err         (key_err),
    .hold_req        (hold_req),
    .rx_en           (rx_en),
    .rcv_data        (rcv_data),
    .rcv_vld         (rcv_vld),
    .rcv_parity_err  (rcv_parity_err),
    .rcv_no_stop_err (rcv_no_stop_err),
    .rcv_idle        (rcv_idle),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .tx_done         (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_pop(input ev_kind_e kind, input logic [7:0] data, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data=%0h, expected none", name, data);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != kind) || (e.data !== data)) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%0h, expected kind=%0d data=%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every output event must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_vld)   mon_pop(EV_KEY,  key_data, "key_vld");
      if (key_err)   mon_pop(EV_KERR, key_data, "key_err");
      if (tx_start)  mon_pop(EV_TXS,  tx_data,  "tx_start");
      if (rsp_valid) mon_pop(EV_RSP,  {6'b0, rsp_status}, "rsp_valid");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic perr, input logic nserr);
    rcv_data        = d;
    rcv_parity_err  = perr;
    rcv_no_stop_err = nserr;
    rcv_vld         = 1'b1;
    tick();
    rcv_vld         = 1'b0;
    rcv_parity_err  = 1'b0;
    rcv_no_stop_err = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] d);
    cmd_data  = d;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx_start(input string name);
    int n = 0;
    while (!tx_start && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(tx_start), 32'd1);
  endtask

  // From SEND: let the transmitter run, pulse tx_done, land in WAIT_ACK entry cycle
  task automatic finish_tx();
    tick();
    check("rx_en_wait_tx", 32'(rx_en), 32'd0);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("rx_en_wait_ack", 32'(rx_en), 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_valid), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    rcv_data = 8'h00; rcv_vld = 1'b0; rcv_parity_err = 1'b0; rcv_no_stop_err = 1'b0;
    rcv_idle = 1'b1; tx_done = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_hold_req",   32'(hold_req),   32'd0);
    check("rst_rx_en",      32'(rx_en),      32'd1);
    check("rst_tx_start",   32'(tx_start),   32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_key_data",   32'(key_data),   32'h00);
    check("rst_tx_data",    32'(tx_data),    32'h00);
    check("rst_key_vld",    32'(key_vld),    32'd0);
    rst_n = 1'b1;
    tick();
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
    rcv_idle = 1'b0;
    #1;
    check("cmd_ready_rx_busy", 32'(cmd_ready), 32'd0);
    rcv_idle = 1'b1;
    tick();

    // Idle receive
    push(EV_KEY, 8'h1C);
    rx_byte(8'h1C, 1'b0, 1'b0);
    tick();

    // Errored byte in idle
`ifdef PS2_AUTO_RESEND_EN
    push(EV_TXS, 8'hFE);
    rx_byte(8'h55, 1'b1, 1'b0);
    wait_tx_start("auto_resend_start");
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("auto_back_idle", 32'(cmd_ready), 32'd1);
`else
    push(EV_KERR, 8'h1C);
    rx_byte(8'h55, 1'b1, 1'b0);
    tick();
`endif

    // Command OK, with a stray byte dropped during WAIT_ACK
    push(EV_TXS, 8'hED);
    push(EV_RSP, 8'h00);
    issue_cmd(8'hED);
    n = 0;
    while (hold_req && n < 100) begin
      if (n == 3) check("cmd_ready_hold", 32'(cmd_ready), 32'd0);
      if (n == 3) check("rx_en_hold", 32'(rx_en), 32'd0);
      tick();
      n++;
    end
    check("hold_len", 32'(n), 32'(HOLD));
    check("tx_start_after_hold", 32'(tx_start), 32'd1);
    finish_tx();
    rx_byte(8'hAA, 1'b0, 1'b0);
    rx_byte(8'hFA, 1'b0, 1'b0);
    wait_rsp("rsp_ok");

    // Retry: RESEND, then errored ACK, then clean ACK
    push(EV_TXS, 8'hFF);
    push(EV_TXS, 8'hFF);
    push(EV_TXS, 8'hFF);
    push(EV_RSP, 8'h00);
    issue_cmd(8'hFF);
    wait_tx_start("retry_tx1");
    finish_tx();
    rx_byte(8'hFE, 1'b0, 1'b0);
    wait_tx_start("retry_tx2");
    finish_tx();
    rx_byte(8'hFA, 1'b0, 1'b1);
    wait_tx_start("retry_tx3");
    finish_tx();
    rx_byte(8'hFA, 1'b0, 1'b0);
    wait_rsp("rsp_retry_ok");

    // Retries exhausted: first attempt + MAXR resends
    for (int i = 0; i <= int'(MAXR); i++) push(EV_TXS, 8'hF4);
    push(EV_RSP, 8'h01);
    issue_cmd(8'hF4);
    for (int i = 0; i <= int'(MAXR); i++) begin
      wait_tx_start("exh_tx");
      finish_tx();
      rx_byte(8'hFE, 1'b0, 1'b0);
    end
    wait_rsp("rsp_exhausted");

    // Timeout: rsp_valid TMO cycles after WAIT_ACK entry
    push(EV_TXS, 8'hF5);
    push(EV_RSP, 8'h02);
    issue_cmd(8'hF5);
    wait_tx_start("tmo_tx");
    finish_tx();
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TMO));
    tick();

    // ACK arriving in the very cycle the timeout fires wins
    push(EV_TXS, 8'hF6);
    push(EV_RSP, 8'h00);
    issue_cmd(8'hF6);
    wait_tx_start("edge_tx");
    finish_tx();
    repeat (TMO - 1) tick();
    rx_byte(8'hFA, 1'b0, 1'b0);
    check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();

    // Reset during HOLD aborts silently
    issue_cmd(8'h12);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_hold_req", 32'(hold_req), 32'd0);
    check("rst_mid_rx_en",    32'(rx_en),    32'd1);
    rst_n = 1'b1;
    tick();
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (HOLD + 5) tick();

    // Receive still works after the abort
    push(EV_KEY, 8'h3A);
    rx_byte(8'h3A, 1'b0, 1'b0);
    repeat (5) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
